// File: rtl/multicycle_cpu_pkg.sv
// Shared definitions for the multicycle MIPS-subset CPU.
// Holds the opcode, funct, ALU-operation and FSM state-code constants, the
// control-word structure passed from the FSM to the datapath, and the small
// arithmetic helpers used by the datapath.
package multicycle_cpu_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operations
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;
  localparam logic [2:0] ALU_ZERO = 3'd5;

  // FSM state codes (visible on the state port)
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADDR  = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_RWB      = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_ADDIEX   = 4'd10;
  localparam logic [3:0] S_ADDIWB   = 4'd11;

  // Source selection for the value latched into ALUOut
  localparam logic [1:0] ALUSEL_BTA   = 2'd0;  // PC + (sext(imm) << 2)
  localparam logic [1:0] ALUSEL_IMM   = 2'd1;  // A + sext(imm)
  localparam logic [1:0] ALUSEL_RTYPE = 2'd2;  // A op B per funct

  // Control word driven by the FSM for the current state
  typedef struct packed {
    logic       ir_we;       // latch memory read data into IR
    logic       pc_inc;      // PC <= PC + 4
    logic       pc_branch;   // PC <= ALUOut when A == B
    logic       pc_jump;     // PC <= {PC[31:28], target, 2'b00}
    logic       ab_we;       // latch register-file reads into A and B
    logic       aluout_we;   // latch ALU result into ALUOut
    logic [1:0] alu_sel;     // ALUSEL_* source for ALUOut
    logic       mdr_we;      // latch memory read data into MDR
    logic       mem_we;      // write B to mem[ALUOut]
    logic       iord;        // memory address: 0 = PC, 1 = ALUOut
    logic       rf_we;       // register-file write enable
    logic       rf_dst_rd;   // destination: 0 = rt, 1 = rd
    logic       rf_src_mdr;  // write data: 0 = ALUOut, 1 = MDR
  } ctrl_t;

  function automatic logic [2:0] funct_to_aluop(input logic [5:0] funct);
    logic [2:0] op;
    case (funct)
      FN_ADD:  op = ALU_ADD;
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_ZERO;  // unknown funct produces 0
    endcase
    return op;
  endfunction

  // Arithmetic wraps modulo 2^32; overflow is not reported.
  function automatic logic [31:0] alu(input logic [2:0] op,
                                      input logic [31:0] x,
                                      input logic [31:0] y);
    logic signed [31:0] sx;
    logic signed [31:0] sy;
    logic [31:0]        r;
    sx = x;
    sy = y;
    case (op)
      ALU_ADD: r = x + y;
      ALU_SUB: r = x - y;
      ALU_AND: r = x & y;
      ALU_OR:  r = x | y;
      ALU_SLT: r = (sx < sy) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/multicycle_cpu_ctrl.sv
// Control FSM of the multicycle CPU.
//   clk, rst_n : clock and asynchronous active-low reset
//   opcode     : IR[31:26] of the instruction being executed
//   state      : current state code
//   ctl        : control word for the datapath in the current state
// Reset forces FETCH; since every write strobe is decoded from the state,
// an instruction interrupted by reset performs no further writes.
module multicycle_cpu_ctrl
  import multicycle_cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  output logic [3:0] state,
  output ctrl_t      ctl
);

  logic [3:0] state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:   state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADDR;
          OP_RTYPE:     state_nxt = S_EXECUTE;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          OP_ADDI:      state_nxt = S_ADDIEX;
          default:      state_nxt = S_FETCH;  // undefined opcode: no-op
        endcase
      end
      S_MEMADDR: state_nxt = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: state_nxt = S_MEMWB;
      S_EXECUTE: state_nxt = S_RWB;
      S_ADDIEX:  state_nxt = S_ADDIWB;
      default:   state_nxt = S_FETCH;  // write-back/branch/jump and codes 12-15
    endcase
  end

  always_comb begin
    ctl = '0;
    case (state)
      S_FETCH: begin
        ctl.ir_we  = 1'b1;
        ctl.pc_inc = 1'b1;
      end
      S_DECODE: begin
        ctl.ab_we     = 1'b1;
        ctl.aluout_we = 1'b1;
        ctl.alu_sel   = ALUSEL_BTA;
      end
      S_MEMADDR, S_ADDIEX: begin
        ctl.aluout_we = 1'b1;
        ctl.alu_sel   = ALUSEL_IMM;
      end
      S_MEMREAD: begin
        ctl.mdr_we = 1'b1;
        ctl.iord   = 1'b1;
      end
      S_MEMWB: begin
        ctl.rf_we      = 1'b1;
        ctl.rf_src_mdr = 1'b1;
      end
      S_MEMWRITE: begin
        ctl.mem_we = 1'b1;
        ctl.iord   = 1'b1;
      end
      S_EXECUTE: begin
        ctl.aluout_we = 1'b1;
        ctl.alu_sel   = ALUSEL_RTYPE;
      end
      S_RWB: begin
        ctl.rf_we     = 1'b1;
        ctl.rf_dst_rd = 1'b1;
      end
      S_BRANCH: ctl.pc_branch = 1'b1;
      S_JUMP:   ctl.pc_jump   = 1'b1;
      S_ADDIWB: ctl.rf_we     = 1'b1;
      default:  ctl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_cpu_mem.sv
// Unified instruction/data memory.
//   clk   : write clock
//   addr  : byte address; the low two bits are ignored
//   we    : write enable (write on rising clk edge)
//   wdata : write data
//   rdata : combinational read data
// Contents are not reset; the array mem is preloaded hierarchically.
module multicycle_cpu_mem #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [31:0]   mem [0:MEM_WORDS-1];
  logic [AW-1:0] idx;

  assign idx   = addr[AW+1:2];
  assign rdata = mem[idx];

  // Address bits outside the word index carry no meaning for this memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

endmodule

// File: rtl/multicycle_cpu_rf.sv
// 32 x 32-bit register file.
//   clk      : write clock
//   ra1/rd1  : combinational read port 1
//   ra2/rd2  : combinational read port 2
//   we/wa/wd : write port, written on rising clk edge
// Register $0 always reads zero and ignores writes. Contents are not reset.
module multicycle_cpu_rf (
  input  logic        clk,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [0:31];

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) regs[wa] <= wd;
  end

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle MIPS-subset CPU (add/sub/and/or/slt, lw, sw, beq, j, addi).
//   clk   : system clock, all state updates on its rising edge
//   rst_n : asynchronous active-low reset (PC, FSM and IR/MDR/A/B/ALUOut)
//   pc    : current program counter
//   state : current control-FSM state code
// The datapath lives here; sequencing comes from multicycle_cpu_ctrl. The
// unified memory (u_mem.mem) and register file (u_rf.regs) are not reset.
module multicycle_cpu
  import multicycle_cpu_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  output logic [3:0]  state
);

  logic [31:0] ir;
  logic [31:0] mdr;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] aluout;

  ctrl_t       ctl;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] alu_y;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [5:0]  funct;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign imm    = ir[15:0];
  assign funct  = ir[5:0];

  multicycle_cpu_ctrl u_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .opcode (opcode),
    .state  (state),
    .ctl    (ctl)
  );

  // Single memory port shared by instruction fetch (PC) and data access (ALUOut).
  assign mem_addr = ctl.iord ? aluout : pc;

  multicycle_cpu_mem #(.MEM_WORDS(MEM_WORDS)) u_mem (
    .clk   (clk),
    .addr  (mem_addr),
    .we    (ctl.mem_we),
    .wdata (b_reg),
    .rdata (mem_rdata)
  );

  assign rf_wa = ctl.rf_dst_rd  ? rd  : rt;
  assign rf_wd = ctl.rf_src_mdr ? mdr : aluout;

  multicycle_cpu_rf u_rf (
    .clk (clk),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rd1),
    .rd2 (rd2),
    .we  (ctl.rf_we),
    .wa  (rf_wa),
    .wd  (rf_wd)
  );

  // In DECODE the PC already holds PC+4, so the branch target is PC+4 relative.
  always_comb begin
    alu_y = 32'd0;
    case (ctl.alu_sel)
      ALUSEL_BTA:   alu_y = pc + (sext16(imm) << 2);
      ALUSEL_IMM:   alu_y = a_reg + sext16(imm);
      ALUSEL_RTYPE: alu_y = alu(funct_to_aluop(funct), a_reg, b_reg);
      default:      alu_y = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= 32'd0;
      ir     <= 32'd0;
      mdr    <= 32'd0;
      a_reg  <= 32'd0;
      b_reg  <= 32'd0;
      aluout <= 32'd0;
    end else begin
      if (ctl.ir_we) ir <= mem_rdata;
      if (ctl.pc_inc)                               pc <= pc + 32'd4;
      else if (ctl.pc_branch && (a_reg == b_reg))   pc <= aluout;
      else if (ctl.pc_jump)                         pc <= {pc[31:28], ir[25:0], 2'b00};
      if (ctl.ab_we) begin
        a_reg <= rd1;
        b_reg <= rd2;
      end
      if (ctl.aluout_we) aluout <= alu_y;
      if (ctl.mdr_we)    mdr    <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: programs are preloaded into u_mem.mem,
// registers into u_rf.regs, and results checked against hand-computed values.
module tb_multicycle_cpu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc;
  logic [3:0]  state;

  int checks = 0;
  int errors = 0;

  multicycle_cpu #(.MEM_WORDS(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pc    (pc),
    .state (state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  // Advance n clock cycles, leaving time 1 ns after the last rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold the CPU in reset and clear memory and registers for a new program.
  task automatic setup();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 256; i++) dut.u_mem.mem[i] = 32'd0;
    for (int i = 0; i < 32; i++)  dut.u_rf.regs[i] = 32'd0;
  endtask

  task automatic go();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    if (pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'd0); end
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++;
    if (dut.ir !== 32'd0) begin errors++; $display("FAIL reset_ir: got %h expected 0", dut.ir); end
    checks++;
    if (dut.aluout !== 32'd0) begin errors++; $display("FAIL reset_aluout: got %h expected 0", dut.aluout); end
    checks++;
    step(1);
  endtask

  task automatic test_arith();
    setup();
    dut.u_rf.regs[1] = 32'd5;
    dut.u_rf.regs[2] = 32'd3;
    dut.u_mem.mem[0] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);  // add $3,$1,$2
    dut.u_mem.mem[1] = enc_r(5'd1, 5'd2, 5'd4, 6'h22);  // sub $4,$1,$2
    dut.u_mem.mem[2] = enc_r(5'd2, 5'd1, 5'd5, 6'h2A);  // slt $5,$2,$1
    go();
    step(12);
    if (dut.u_rf.regs[3] !== 32'd8) begin errors++; $display("FAIL arith_add: got %h expected %h", dut.u_rf.regs[3], 32'd8); end
    checks++;
    if (dut.u_rf.regs[4] !== 32'd2) begin errors++; $display("FAIL arith_sub: got %h expected %h", dut.u_rf.regs[4], 32'd2); end
    checks++;
    if (dut.u_rf.regs[5] !== 32'd1) begin errors++; $display("FAIL arith_slt: got %h expected %h", dut.u_rf.regs[5], 32'd1); end
    checks++;
    if (pc !== 32'd12) begin errors++; $display("FAIL arith_pc: got %h expected %h", pc, 32'd12); end
    checks++;
  endtask

  task automatic test_alu_edges();
    setup();
    dut.u_rf.regs[1] = 32'hFFFF_FFFF;
    dut.u_rf.regs[2] = 32'd1;
    dut.u_rf.regs[8] = 32'h7FFF_FFFF;
    dut.u_rf.regs[9] = 32'd99;
    dut.u_mem.mem[0] = enc_r(5'd1, 5'd2, 5'd6, 6'h2A);  // slt $6,$1,$2 : -1 < 1
    dut.u_mem.mem[1] = enc_r(5'd8, 5'd2, 5'd7, 6'h20);  // add $7,$8,$2 : wraps
    dut.u_mem.mem[2] = enc_r(5'd1, 5'd2, 5'd9, 6'h3F);  // unknown funct -> 0
    go();
    step(12);
    if (dut.u_rf.regs[6] !== 32'd1) begin errors++; $display("FAIL slt_signed: got %h expected %h", dut.u_rf.regs[6], 32'd1); end
    checks++;
    if (dut.u_rf.regs[7] !== 32'h8000_0000) begin errors++; $display("FAIL add_overflow: got %h expected %h", dut.u_rf.regs[7], 32'h8000_0000); end
    checks++;
    if (dut.u_rf.regs[9] !== 32'd0) begin errors++; $display("FAIL bad_funct: got %h expected %h", dut.u_rf.regs[9], 32'd0); end
    checks++;
  endtask

  task automatic test_memory();
    logic [3:0] exp_st [5];
    exp_st = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    setup();
    dut.u_mem.mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'h0040);  // addi $1,$0,0x40
    dut.u_mem.mem[1] = enc_i(6'h2B, 5'd1, 5'd1, 16'h0000);  // sw $1,0($1)
    dut.u_mem.mem[2] = enc_i(6'h23, 5'd1, 5'd2, 16'h0000);  // lw $2,0($1)
    go();
    step(4);
    if (dut.u_rf.regs[1] !== 32'h40) begin errors++; $display("FAIL addi_result: got %h expected %h", dut.u_rf.regs[1], 32'h40); end
    checks++;
    step(4);
    if (dut.u_mem.mem[16] !== 32'h40) begin errors++; $display("FAIL sw_mem16: got %h expected %h", dut.u_mem.mem[16], 32'h40); end
    checks++;
    if (pc !== 32'd8) begin errors++; $display("FAIL sw_pc: got %h expected %h", pc, 32'd8); end
    checks++;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (state !== exp_st[i]) begin errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, exp_st[i]); end
      checks++;
    end
    if (dut.u_rf.regs[2] !== 32'h40) begin errors++; $display("FAIL lw_result: got %h expected %h", dut.u_rf.regs[2], 32'h40); end
    checks++;
    if (pc !== 32'd12) begin errors++; $display("FAIL lw_pc: got %h expected %h", pc, 32'd12); end
    checks++;
  endtask

  task automatic test_self_modify();
    setup();
    dut.u_rf.regs[1] = enc_i(6'h08, 5'd0, 5'd7, 16'd9);     // addi $7,$0,9
    dut.u_mem.mem[0] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0004);  // sw $1,4($0)
    go();
    step(8);
    if (dut.u_rf.regs[7] !== 32'd9) begin errors++; $display("FAIL self_modify: got %h expected %h", dut.u_rf.regs[7], 32'd9); end
    checks++;
  endtask

  task automatic test_branch();
    setup();
    dut.u_rf.regs[1] = 32'd7;
    dut.u_rf.regs[2] = 32'd7;
    dut.u_mem.mem[0] = enc_i(6'h04, 5'd1, 5'd2, 16'd2);  // beq $1,$2,+2
    go();
    step(2);
    if (state !== 4'd8) begin errors++; $display("FAIL beq_state: got %0d expected 8", state); end
    checks++;
    step(1);
    if (pc !== 32'd12) begin errors++; $display("FAIL beq_taken_pc: got %h expected %h", pc, 32'd12); end
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL beq_done_state: got %0d expected 0", state); end
    checks++;
    setup();
    dut.u_rf.regs[1] = 32'd7;
    dut.u_rf.regs[2] = 32'd6;
    dut.u_mem.mem[0] = enc_i(6'h04, 5'd1, 5'd2, 16'd2);
    go();
    step(3);
    if (pc !== 32'd4) begin errors++; $display("FAIL beq_not_taken_pc: got %h expected %h", pc, 32'd4); end
    checks++;
  endtask

  task automatic test_jump_zero();
    setup();
    dut.u_mem.mem[0]  = enc_j(6'h02, 26'h10);                  // j 0x10
    dut.u_mem.mem[16] = enc_i(6'h08, 5'd0, 5'd0, 16'd5);       // addi $0,$0,5
    go();
    step(2);
    if (state !== 4'd9) begin errors++; $display("FAIL j_state: got %0d expected 9", state); end
    checks++;
    step(1);
    if (pc !== 32'h40) begin errors++; $display("FAIL j_pc: got %h expected %h", pc, 32'h40); end
    checks++;
    step(4);
    if (dut.u_rf.regs[0] !== 32'd0) begin errors++; $display("FAIL zero_reg: got %h expected %h", dut.u_rf.regs[0], 32'd0); end
    checks++;
    if (pc !== 32'h44) begin errors++; $display("FAIL addi0_pc: got %h expected %h", pc, 32'h44); end
    checks++;
  endtask

  task automatic test_undefined();
    setup();
    dut.u_mem.mem[0] = 32'hFC00_0000;  // opcode 0x3F
    go();
    step(1);
    if (state !== 4'd1) begin errors++; $display("FAIL undef_decode: got %0d expected 1", state); end
    checks++;
    step(1);
    if (state !== 4'd0) begin errors++; $display("FAIL undef_state: got %0d expected 0", state); end
    checks++;
    if (pc !== 32'd4) begin errors++; $display("FAIL undef_pc: got %h expected %h", pc, 32'd4); end
    checks++;
  endtask

  task automatic test_reset_mid();
    setup();
    dut.u_rf.regs[3] = 32'hAA;
    dut.u_mem.mem[0] = enc_i(6'h23, 5'd0, 5'd3, 16'd8);  // lw $3,8($0)
    dut.u_mem.mem[2] = 32'h1234;
    go();
    step(3);
    if (state !== 4'd3) begin errors++; $display("FAIL mid_state_before: got %0d expected 3", state); end
    checks++;
    rst_n = 1'b0;
    #1;
    if (pc !== 32'd0) begin errors++; $display("FAIL mid_reset_pc: got %h expected 0", pc); end
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL mid_reset_state: got %0d expected 0", state); end
    checks++;
    step(1);
    if (dut.u_rf.regs[3] !== 32'hAA) begin errors++; $display("FAIL mid_reset_rf: got %h expected %h", dut.u_rf.regs[3], 32'hAA); end
    checks++;
    rst_n = 1'b1;
    step(5);
    if (dut.u_rf.regs[3] !== 32'h1234) begin errors++; $display("FAIL restart_lw: got %h expected %h", dut.u_rf.regs[3], 32'h1234); end
    checks++;
    if (pc !== 32'd4) begin errors++; $display("FAIL restart_pc: got %h expected %h", pc, 32'd4); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_alu_edges();
    test_memory();
    test_self_modify();
    test_branch();
    test_jump_zero();
    test_undefined();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256: depth of the unified instruction/data memory in 32-bit words.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port pc, output, 32 bits: current program counter.
REQ-005 SHALL have port state, output, 4 bits: current control-FSM state code.

Function
REQ-006 SHALL execute the 32-bit MIPS subset: add, sub, and, or, slt (R-type, op 0x00, funct 0x20/0x22/0x24/0x25/0x2A); lw 0x23; sw 0x2B; beq 0x04; j 0x02; addi 0x08.
REQ-007 SHALL use a single unified memory for instructions and data, with byte addresses and word index = addr[log2(MEM_WORDS)+1:2].
  - Memory read: combinational.
  - Memory write: on the clock edge.
  - Low two address bits: ignored.
REQ-008 SHALL use a 32x32 register file with two combinational read ports and one write port that writes on the clock edge; $0 SHALL read 0 and ignore writes.
REQ-009 SHALL hold the internal registers IR, MDR, A, B and ALUOut, each updated at the end of each state.
REQ-010 SHALL implement the FSM states below; the state code is the number given.
  - 0 FETCH: IR<=mem[PC]; PC<=PC+4; ->1.
  - 1 DECODE: A<=RF[rs]; B<=RF[rt]; ALUOut<=PC+(sext(imm)<<2). Next state by opcode: lw/sw ->2, R ->6, beq ->8, j ->9, addi ->10, any other opcode ->0 (no-op).
  - 2 MEMADDR: ALUOut<=A+sext(imm); lw ->3, sw ->5.
  - 3 MEMREAD: MDR<=mem[ALUOut]; ->4.
  - 4 MEMWB: RF[rt]<=MDR; ->0.
  - 5 MEMWRITE: mem[ALUOut]<=B; ->0.
  - 6 EXECUTE: ALUOut<=A op B per funct; ->7.
  - 7 RWB: RF[rd]<=ALUOut; ->0.
  - 8 BRANCH: if A==B then PC<=ALUOut; ->0.
  - 9 JUMP: PC<={PC[31:28], IR[25:0], 2'b00}; ->0.
  - 10 ADDIEX: ALUOut<=A+sext(imm); ->11.
  - 11 ADDIWB: RF[rt]<=ALUOut; ->0.
  - Codes 12-15: ->0 with no side effects.
REQ-011 SHALL produce per-instruction latency in cycles: lw 5; sw, R-type, addi 4; beq, j 3; undefined opcode 2.
REQ-012 SHALL perform all arithmetic modulo 2^32 with overflow ignored (no exception).
  - slt: signed compare, result 1 or 0.
  - Unknown funct in EXECUTE: writes 0 to rd.
REQ-013 SHALL compute the branch target relative to PC+4 (the PC already incremented in FETCH).
REQ-014 SHALL let an instruction in FETCH read the value stored by an immediately preceding sw (self-modifying code permitted).

Reset
REQ-015 SHALL, while rst_n=0 (asynchronously), force PC=0, state=0 and IR/MDR/A/B/ALUOut=0.
REQ-016 SHALL NOT reset the register file or memory contents, so a bench can preload them with $readmemh before or after reset.
REQ-017 SHALL abandon any instruction in progress when reset is asserted mid-instruction, performing no further write, and on release restart fetching at address 0.

Structure
REQ-018 SHALL place opcode, funct, ALU-operation and FSM state-code constants in a shared package, multicycle_cpu_pkg.
REQ-019 SHALL expose the memory array as instance u_mem, array mem[0:MEM_WORDS-1], and the register file as instance u_rf, array regs[0:31], both hierarchically accessible for bench preload.
REQ-020 SHALL use the control FSM as the one natural sub-module, multicycle_cpu_ctrl (opcode in, control signals and state out); the datapath stays in the top module.

Verification
REQ-021 Arithmetic: preload $1=5, $2=3, program add $3,$1,$2; sub $4,$1,$2; slt $5,$2,$1 -> $3=8, $4=2, $5=1 after 12 cycles.
REQ-022 Memory: addi $1,$0,0x40; sw $1,0($1); lw $2,0($1) -> mem word 16 = 0x40, $2=0x40; lw takes exactly 5 cycles (state sequence 0,1,2,3,4).
REQ-023 Branch: $1=$2=7, beq $1,$2,+2 -> PC = branch_addr+4+8; with $2=6, PC = branch_addr+4.
REQ-024 Jump/zero register: j 0x10 -> PC=0x40; addi $0,$0,5 -> $0 stays 0.
REQ-025 Reset: assert rst_n=0 during state 3 of an lw -> PC=0 and state=0 immediately, destination register unchanged, execution restarts from 0 after release.
